protobuf_varint_encoder: RTL and testbench

- Parametrised successor to the fixed 32-bit varint path of the serializer. Encodes one field per input transaction into a byte stream: optional protobuf key (field_number<<3 | wire type 0) followed by the value varint.
- Supports uint, int (sign-extended to 64 bits per protobuf) and sint (zigzag) modes at DATA_W of 32 or 64.
- Sits between the AXI write-side input FIFOs and the byte-merge/output FIFO.
- Valid/ready on both sides; carries the field index through to every output byte.

---
 rtl/protobuf_varint_encoder_pkg.sv | 25 ++
 rtl/protobuf_varint_encoder_value_prep.sv | 26 ++
 rtl/protobuf_varint_encoder.sv | 148 ++++++++++++++
 tb/tb_protobuf_varint_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/protobuf_varint_encoder_pkg.sv
// Shared constants, mode encodings, FSM states and sizing helper for the varint encoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pb_pkg;

    // Protobuf wire type for varint fields, placed in the low 3 bits of the key
    localparam logic [2:0] WT_VARINT = 3'd0;

    // in_mode encodings; 2'b11 is reserved and encodes like uint
    localparam logic [1:0] MODE_UINT = 2'b00;
    localparam logic [1:0] MODE_INT  = 2'b01;
    localparam logic [1:0] MODE_SINT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        VAL  = 2'd2
    } state_t;

    // Number of 7-bit varint groups needed to carry a value of the given bit width
    function automatic int varint_max_bytes(input int width);
        return (width + 6) / 7;
    endfunction

endpackage

// File: rtl/protobuf_varint_encoder_value_prep.sv
// Widens a raw field value to the 64-bit quantity that gets varint-encoded (uint/int/sint).
// Latency: purely combinational.
// Backpressure: none; the value is sampled by the parent at accept.
module pb_value_prep
    import pb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        mode_i,
    output logic [63:0]       value_o
);

    logic [DATA_W-1:0] zz;

    // Zigzag stays in DATA_W bits so a 32-bit sint never produces more than 5 value bytes
    always_comb begin
        zz = (data_i << 1) ^ {DATA_W{data_i[DATA_W-1]}};
        case (mode_i)
            MODE_INT:  value_o = 64'($signed(data_i));
            MODE_SINT: value_o = 64'(zz);
            default:   value_o = 64'(data_i);
        endcase
    end

endmodule

// File: rtl/protobuf_varint_encoder.sv
// Encodes one field per request into a byte stream: optional key varint followed by value varint.
// Latency: first byte valid the cycle after accept, then 1 byte/cycle while out_ready is high.
// Backpressure: outputs hold while out_valid & !out_ready; in_ready only in IDLE or on the last byte.
module protobuf_varint_encoder
    import pb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int FIELD_W  = 10,
    parameter int IDX_W    = 10,
    parameter int EMIT_TAG = 1
) (
    input  logic               clock_clk,
    input  logic               reset_reset,
    input  logic               sclr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [1:0]         in_mode,
    input  logic [FIELD_W-1:0] in_field,
    input  logic [IDX_W-1:0]   in_index,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_is_key,
    output logic               out_last,
    output logic [15:0]        byte_count,
    output logic               err_field_zero
);

    // Key register is at least 8 bits so the low 7-bit slice always exists for tiny FIELD_W
    localparam int KREG_W = (FIELD_W + 3 < 8) ? 8 : FIELD_W + 3;

    state_t              state_q, state_d;
    logic [63:0]         v_q, v_d;
    logic [KREG_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [63:0]         prep_val;
    logic [63:0]         v_rest;
    logic [KREG_W-1:0]   k_rest;
    logic                hs;
    logic                acc;

    pb_value_prep #(.DATA_W(DATA_W)) u_value_prep (
        .data_i  (in_data),
        .mode_i  (in_mode),
        .value_o (prep_val)
    );

    assign v_rest     = v_q >> 7;
    assign k_rest     = k_q >> 7;
    assign out_valid  = (state_q != IDLE);
    assign out_index  = out_valid ? idx_q : '0;
    assign hs         = out_valid & out_ready;
    assign in_ready   = (state_q == IDLE) | (hs & out_last);
    assign acc        = in_valid & in_ready;
    assign byte_count = cnt_q;
    assign err_field_zero = err_q;

    // Current byte is the low 7 bits of the active register, continuation set while bits remain
    always_comb begin
        out_byte   = '0;
        out_is_key = 1'b0;
        out_last   = 1'b0;
        case (state_q)
            KEY: begin
                out_byte   = {k_rest != '0, k_q[6:0]};
                out_is_key = 1'b1;
            end
            VAL: begin
                out_byte = {v_rest != '0, v_q[6:0]};
                out_last = (v_rest == '0);
            end
            default: ;
        endcase
    end

    // Shift on handshake, reload on accept (accept may coincide with the last byte), sclr overrides all
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        k_d     = k_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (hs) begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            case (state_q)
                KEY: begin
                    k_d = k_rest;
                    if (k_rest == '0) state_d = VAL;
                end
                VAL: begin
                    v_d = v_rest;
                    if (v_rest == '0) state_d = IDLE;
                end
                default: ;
            endcase
        end

        if (acc) begin
            v_d   = prep_val;
            k_d   = KREG_W'({in_field, WT_VARINT});
            idx_d = in_index;
            if (EMIT_TAG != 0) begin
                // A key of field 0 is illegal: flag it and drop the whole field
                if (in_field == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = KEY;
                end
            end else begin
                state_d = VAL;
            end
        end

        if (sclr) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    // State, shift registers and counters
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            v_q     <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_protobuf_varint_encoder.sv
// Bench for protobuf_varint_encoder: directed literal cases plus randomized traffic vs a queue model.
// Latency: checks first byte one cycle after accept and back-to-back fields without bubbles.
// Backpressure: random and directed out_ready stalls.
module tb_protobuf_varint_encoder;

    localparam int DATA_W  = 32;
    localparam int FIELD_W = 10;
    localparam int IDX_W   = 10;
    localparam int MAXB    = pb_pkg::varint_max_bytes(FIELD_W + 3) + 10;

    logic               clock_clk = 1'b0;
    logic               reset_reset, sclr, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0]  in_data;
    logic [1:0]         in_mode;
    logic [FIELD_W-1:0] in_field;
    logic [IDX_W-1:0]   in_index, out_index;
    logic [7:0]         out_byte;
    logic               out_is_key, out_last, err_field_zero;
    logic [15:0]        byte_count;

    protobuf_varint_encoder #(
        .DATA_W(DATA_W), .FIELD_W(FIELD_W), .IDX_W(IDX_W), .EMIT_TAG(1)
    ) dut (
        .clock_clk(clock_clk), .reset_reset(reset_reset), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .in_field(in_field), .in_index(in_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_index(out_index), .out_is_key(out_is_key), .out_last(out_last),
        .byte_count(byte_count), .err_field_zero(err_field_zero)
    );

    typedef struct packed {
        logic [7:0]       b;
        logic [IDX_W-1:0] idx;
        logic             key;
        logic             last;
    } exp_t;

    typedef struct packed {
        logic [7:0]  b;
        logic        key;
        logic        last;
        logic [31:0] cyc;
    } log_t;

    exp_t       expq[$];
    log_t       logq[$];
    logic [7:0] want[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         fld_len = 0;
    logic [15:0] exp_cnt = '0;
    logic       exp_err = 1'b0;
    bit         rnd_rdy = 1'b0;

    always #5 clock_clk = ~clock_clk;
    always @(posedge clock_clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference varint: base-128 digits, least significant first, continuation on all but last
    function automatic void push_varint(input logic [63:0] v, input bit key,
                                        input logic [IDX_W-1:0] idx, input bit fin);
        exp_t e;
        logic [63:0] r;
        r = v;
        do begin
            e.b    = 8'(r % 128);
            r      = r / 128;
            e.b[7] = (r != 0);
            e.idx  = idx;
            e.key  = key;
            e.last = fin && (r == 0);
            expq.push_back(e);
        end while (r != 0);
    endfunction

    function automatic void model_push(input logic [DATA_W-1:0] d, input logic [1:0] mode,
                                       input logic [FIELD_W-1:0] f, input logic [IDX_W-1:0] idx);
        longint signed   s;
        longint unsigned v;
        s = $signed(d);
        case (mode)
            2'b01:   v = s;
            2'b10:   v = (s >= 0) ? 2 * s : -2 * s - 1;
            default: v = 64'(d);
        endcase
        if (f == 0) begin
            exp_err = 1'b1;
            return;
        end
        push_varint(64'(f) * 8, 1'b1, idx, 1'b0);
        push_varint(v, 1'b0, idx, 1'b1);
    endfunction

    // Single compare process: every falling edge, DUT outputs vs model queue
    always @(negedge clock_clk) begin
        log_t lg;
        if (reset_reset || sclr) begin
            expq.delete();
            exp_cnt = '0;
            exp_err = 1'b0;
            fld_len = 0;
        end else begin
            chk("in_ready", in_ready, (expq.size() == 0) || (out_ready && expq[0].last));
            chk("out_valid", out_valid, expq.size() != 0);
            chk("byte_count", byte_count, exp_cnt);
            chk("err_field_zero", err_field_zero, exp_err);
            if (out_valid && expq.size() != 0) begin
                chk("out_byte", out_byte, expq[0].b);
                chk("out_index", out_index, expq[0].idx);
                chk("out_is_key", out_is_key, expq[0].key);
                chk("out_last", out_last, expq[0].last);
                if (out_ready) begin
                    lg = {out_byte, out_is_key, out_last, 32'(cyc)};
                    logq.push_back(lg);
                    fld_len++;
                    if (expq[0].last) begin
                        chk("field_len_max", fld_len <= MAXB, 1);
                        fld_len = 0;
                    end
                    void'(expq.pop_front());
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                model_push(in_data, in_mode, in_field, in_index);
            end
        end
    end

    always @(posedge clock_clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic [1:0] m,
                        input logic [FIELD_W-1:0] f, input logic [IDX_W-1:0] idx);
        bit ok;
        ok = 1'b0;
        in_data = d; in_mode = m; in_field = f; in_index = idx; in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock_clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 1, 0);
        @(posedge clock_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(posedge clock_clk); #2;
            if (expq.size() == 0 && !out_valid) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic check_bytes(input string name);
        chk({name, "_len"}, logq.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            chk($sformatf("%s_b%0d", name, i), logq[i].b, want[i]);
    endtask

    initial begin
        reset_reset = 1'b1; sclr = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
        in_field = '0; in_index = '0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_err", err_field_zero, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock_clk); #1;
        @(posedge clock_clk); #1;
        reset_reset = 1'b0;

        // uint 300, field 1
        logq.delete();
        send(32'd300, 2'b00, 10'd1, 10'd7);
        wait_idle(100);
        want = '{8'h08, 8'hAC, 8'h02};
        check_bytes("t1");
        chk("t1_keys", {logq[0].key, logq[1].key, logq[2].key}, 3'b100);
        chk("t1_lasts", {logq[0].last, logq[1].last, logq[2].last}, 3'b001);
        chk("t1_latency", logq[0].cyc, acc_cyc + 1);

        // int -1, field 2, after a clear so the count is this field alone
        sclr = 1'b1;
        @(posedge clock_clk); #1;
        sclr = 1'b0;
        logq.delete();
        send(32'hFFFF_FFFF, 2'b01, 10'd2, 10'd1);
        wait_idle(100);
        want = '{8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        check_bytes("t2");
        chk("t2_count", byte_count, 11);

        // sint -1 and sint INT_MAX, field 3
        logq.delete();
        send(32'hFFFF_FFFF, 2'b10, 10'd3, 10'd2);
        wait_idle(100);
        want = '{8'h18, 8'h01};
        check_bytes("t3a");
        logq.delete();
        send(32'h7FFF_FFFF, 2'b10, 10'd3, 10'd3);
        wait_idle(100);
        want = '{8'h18, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        check_bytes("t3b");

        // field 16, uint 0, with a 3-cycle stall after the first byte
        logq.delete();
        send(32'd0, 2'b00, 10'd16, 10'd4);
        for (int i = 0; i < 50; i++) begin
            if (logq.size() >= 1) break;
            @(posedge clock_clk); #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clock_clk);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_byte", out_byte, 8'h01);
        end
        @(posedge clock_clk); #1;
        out_ready = 1'b1;
        wait_idle(100);
        want = '{8'h80, 8'h01, 8'h00};
        check_bytes("t4");

        // back-to-back fields with no idle cycle
        logq.delete();
        send(32'd1, 2'b00, 10'd1, 10'd5);
        send(32'd2, 2'b00, 10'd2, 10'd6);
        wait_idle(100);
        want = '{8'h08, 8'h01, 8'h10, 8'h02};
        check_bytes("t5");
        chk("t5_nobubble", logq[3].cyc - logq[0].cyc, 3);

        // field 0: no output, sticky error, ready again next cycle
        logq.delete();
        send(32'd5, 2'b00, 10'd0, 10'd7);
        @(negedge clock_clk);
        chk("t6_err", err_field_zero, 1);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_out_valid", out_valid, 0);
        wait_idle(20);
        chk("t6_no_bytes", logq.size(), 0);

        // async reset in the middle of the value bytes
        send(32'hFFFF_FFFF, 2'b00, 10'd1, 10'd9);
        @(posedge clock_clk); #1;
        chk("t7_midval", {out_valid, out_is_key}, 2'b10);
        #2 reset_reset = 1'b1;
        #1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_count", byte_count, 0);
        chk("t7_rst_err", err_field_zero, 0);
        @(posedge clock_clk); #1;
        reset_reset = 1'b0;

        // sclr mid-field, then a clean field
        send(32'd3, 2'b00, 10'd0, 10'd0);
        send(32'hFFFF_FFFF, 2'b01, 10'd5, 10'd10);
        @(posedge clock_clk); #1;
        @(posedge clock_clk); #1;
        sclr = 1'b1;
        @(posedge clock_clk); #1;
        sclr = 1'b0;
        chk("t8_valid", out_valid, 0);
        chk("t8_count", byte_count, 0);
        chk("t8_err", err_field_zero, 0);
        logq.delete();
        send(32'd150, 2'b00, 10'd1, 10'd11);
        wait_idle(100);
        want = '{8'h08, 8'h96, 8'h01};
        check_bytes("t8");

        // randomized traffic with random backpressure against the model
        rnd_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [DATA_W-1:0]  d;
            logic [FIELD_W-1:0] f;
            repeat ($urandom % 3) begin @(posedge clock_clk); #1; end
            case ($urandom % 5)
                0:       d = '0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'($urandom % 128);
                3:       d = {1'b1, 31'($urandom)};
                default: d = 32'($urandom);
            endcase
            f = (($urandom % 20) == 0) ? 10'd0 : 10'($urandom);
            send(d, 2'($urandom), f, 10'($urandom));
        end
        rnd_rdy = 1'b0;
        @(posedge clock_clk); #2;
        out_ready = 1'b1;
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
